// File: rtl/wb_player_pkg.sv
// Shared state encoding, bus constants and lane helper for the Wishbone pattern player.
package wb_player_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    BACKOFF,
    GAP
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  function automatic logic [3:0] lane_sel(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/wb_player_gap_timer.sv
// Loadable down-counter; done pulses for one cycle as the count steps from 1 to 0.
module wb_player_gap_timer #(
  parameter int W = 16
) (
  input  logic         clk_sys,
  input  logic         rst_b,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/wb_pattern_player.sv
// Wishbone classic master replaying a ROM word table into a byte-wide output peripheral.
// Define PLAYER_TIMEOUT_EN to add a 1023-cycle stalled-access watchdog.
//   state   | meaning
//   IDLE    | waiting for en_i
//   RD      | table word read (stb low for one setup cycle after a completed access)
//   WR      | one output byte write per access
//   BACKOFF | one idle cycle after rty, then the same access again
//   GAP     | GAP_CYCLES idle cycles after a word
module wb_pattern_player
  import wb_player_pkg::*;
#(
  parameter logic [31:0] SRC_BASE   = 32'h0800_0000,
  parameter int          SRC_WORDS  = 10,
  parameter logic [31:0] DST_BASE   = 32'h9100_0000,
  parameter int          DST_BYTES  = 2,
  parameter int          GAP_CYCLES = 0,
  localparam int         IDX_W      = (SRC_WORDS > 1) ? $clog2(SRC_WORDS) : 1
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic             en_i,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic             wb_rty_i,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_we_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic [2:0]       wb_cti_o,
  output logic [1:0]       wb_bte_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [IDX_W-1:0] word_idx_o
);

  state_t           state_q, state_n;
  logic             stb_q, stb_n;
  logic [31:0]      adr_q, adr_n, dat_q, dat_n, rdata_q, rdata_n;
  logic [3:0]       sel_q, sel_n;
  logic [IDX_W-1:0] idx_q, idx_n, idx_nx;
  logic [1:0]       bidx_q, bidx_n, bidx_nx;
  logic             bo_wr_q, bo_wr_n, err_q, err_n;
  logic             gap_load, gap_done, word_end, advance, bus_err, wd_abort;
  logic [31:0]      wr_adr;
  logic [7:0]       wr_byte;

  wb_player_gap_timer #(.W(16)) u_gap (
    .clk_sys  (wb_clk),
    .rst_b    (wb_rst_n),
    .load     (gap_load),
    .load_val (16'(GAP_CYCLES)),
    .done     (gap_done)
  );

`ifdef PLAYER_TIMEOUT_EN
  logic wd_load, wd_done;

  // Every access (including a retried one) starts with stb rising, which reloads the watchdog.
  assign wd_load  = stb_n & ~stb_q;
  assign wd_abort = wd_done & stb_q;

  wb_player_gap_timer #(.W(10)) u_wd (
    .clk_sys  (wb_clk),
    .rst_b    (wb_rst_n),
    .load     (wd_load),
    .load_val (10'd1023),
    .done     (wd_done)
  );
`else
  assign wd_abort = 1'b0;
`endif

  assign bus_err = wb_err_i | wd_abort;

  always_comb begin
    state_n  = state_q;
    stb_n    = stb_q;
    adr_n    = adr_q;
    dat_n    = dat_q;
    sel_n    = sel_q;
    idx_n    = idx_q;
    bidx_n   = bidx_q;
    rdata_n  = rdata_q;
    bo_wr_n  = bo_wr_q;
    err_n    = err_q;
    gap_load = 1'b0;
    word_end = 1'b0;
    advance  = 1'b0;
    idx_nx   = (idx_q == IDX_W'(SRC_WORDS - 1)) ? '0 : idx_q + IDX_W'(1);
    bidx_nx  = bidx_q + 2'd1;
    wr_adr   = DST_BASE + 32'(bidx_nx);
    wr_byte  = 8'(rdata_q >> {bidx_nx, 3'b000});

    case (state_q)
      IDLE: if (en_i) begin
        state_n = RD;
        adr_n   = SRC_BASE + (32'(idx_q) << 2);
        sel_n   = 4'hF;
        stb_n   = 1'b1;
      end
      RD, WR: begin
        // stb low here is the mandatory idle cycle between accesses
        if (!stb_q) stb_n = 1'b1;
        else if (bus_err) begin
          err_n    = 1'b1;
          stb_n    = 1'b0;
          word_end = 1'b1;
        end else if (wb_rty_i) begin
          stb_n   = 1'b0;
          bo_wr_n = (state_q == WR);
          state_n = BACKOFF;
        end else if (wb_ack_i) begin
          stb_n = 1'b0;
          if (state_q == RD) begin
            rdata_n = wb_dat_i;
            bidx_n  = '0;
            adr_n   = DST_BASE;
            dat_n   = {4{wb_dat_i[7:0]}};
            sel_n   = lane_sel(DST_BASE[1:0]);
            state_n = WR;
          end else if (bidx_q == 2'(DST_BYTES - 1)) begin
            word_end = 1'b1;
          end else begin
            bidx_n = bidx_nx;
            adr_n  = wr_adr;
            dat_n  = {4{wr_byte}};
            sel_n  = lane_sel(wr_adr[1:0]);
          end
        end
      end
      BACKOFF: begin
        state_n = bo_wr_q ? WR : RD;
        stb_n   = 1'b1;
      end
      GAP: if (gap_done) advance = 1'b1;
      default: state_n = IDLE;
    endcase

    if (word_end) begin
      if (GAP_CYCLES != 0) begin
        state_n  = GAP;
        gap_load = 1'b1;
      end else begin
        advance = 1'b1;
      end
    end

    // en_i is only looked at here, so a started word always finishes
    if (advance) begin
      idx_n = idx_nx;
      if (en_i) begin
        state_n = RD;
        adr_n   = SRC_BASE + (32'(idx_nx) << 2);
        sel_n   = 4'hF;
      end else begin
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      adr_q   <= SRC_BASE;
      dat_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      bidx_q  <= '0;
      rdata_q <= '0;
      bo_wr_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      stb_q   <= stb_n;
      adr_q   <= adr_n;
      dat_q   <= dat_n;
      sel_q   <= sel_n;
      idx_q   <= idx_n;
      bidx_q  <= bidx_n;
      rdata_q <= rdata_n;
      bo_wr_q <= bo_wr_n;
      err_q   <= err_n;
    end
  end

  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;
  assign wb_cyc_o   = stb_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = stb_q & (state_q == WR);
  assign wb_cti_o   = CTI_CLASSIC;
  assign wb_bte_o   = BTE_LINEAR;
  assign busy_o     = (state_q != IDLE);
  assign err_o      = err_q;
  assign word_idx_o = idx_q;

endmodule

// File: tb/tb_wb_pattern_player.sv
// Scoreboard bench for wb_pattern_player: a zero-wait slave pops expected accesses and answers them.
module tb_wb_pattern_player;

  localparam logic [31:0] SRC_BASE   = 32'h0800_0000;
  localparam logic [31:0] DST_BASE   = 32'h9100_0000;
  localparam int          SRC_WORDS  = 3;
  localparam int          DST_BYTES  = 2;
  localparam int          GAP_CYCLES = 5;
  localparam int R_ACK = 0, R_RTY = 1, R_ERR = 2, R_HOLD = 3;

  logic        wb_clk = 1'b0, wb_rst_n = 1'b0, en_i = 1'b0;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, busy_o, err_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o, word_idx_o;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          idle;
    int          idx;
    logic        err;
    int          resp;
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] rom [SRC_WORDS] = '{32'hA1B2_C3D4, 32'h1122_3344, 32'h5566_7788};
  int          n_checks = 0, n_errors = 0, idle_run = 0, hold_cnt = 0;
  bit          quiet = 1'b0;

  wb_pattern_player #(
    .SRC_BASE(SRC_BASE), .SRC_WORDS(SRC_WORDS), .DST_BASE(DST_BASE),
    .DST_BYTES(DST_BYTES), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .en_i(en_i),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .busy_o(busy_o), .err_o(err_o), .word_idx_o(word_idx_o)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_rd(input int idx, input int idle, input logic err, input int resp);
    acc_t a;
    a.we = 1'b0; a.adr = SRC_BASE + 32'(idx) * 32'd4; a.sel = 4'hF; a.dat = '0;
    a.idle = idle; a.idx = idx; a.err = err; a.resp = resp;
    exp_q.push_back(a);
  endtask

  task automatic push_wr(input int idx, input int b, input int idle, input logic err, input int resp);
    acc_t        a;
    logic [31:0] w;
    logic [7:0]  by;
    w  = rom[idx];
    by = w[8*b +: 8];
    a.we = 1'b1; a.adr = DST_BASE + 32'(b); a.sel = 4'b0001 << a.adr[1:0]; a.dat = {4{by}};
    a.idle = idle; a.idx = idx; a.err = err; a.resp = resp;
    exp_q.push_back(a);
  endtask

  // Zero-wait slave: answers in the same cycle stb is seen.
  task automatic slave_loop();
    acc_t a;
    forever begin
      @(negedge wb_clk);
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      if (!wb_stb_o) idle_run++;
      else if (quiet) hold_cnt++;
      else begin
        if (exp_q.size() == 0) begin
          chk("extra_access", 32'(exp_q.size()), 32'd1);
          wb_ack_i = 1'b1;
        end else begin
          a = exp_q.pop_front();
          chk("we", 32'(wb_we_o), 32'(a.we));
          chk("cyc", 32'(wb_cyc_o), 32'd1);
          chk("adr", wb_adr_o, a.adr);
          chk("sel", 32'(wb_sel_o), 32'(a.sel));
          if (a.we) chk("dat", wb_dat_o, a.dat);
          else      chk("word_idx", 32'(word_idx_o), 32'(a.idx));
          if (a.idle >= 0) chk("idle_cycles", 32'(idle_run), 32'(a.idle));
          chk("err_o", 32'(err_o), 32'(a.err));
          wb_dat_i = rom[a.idx];
          case (a.resp)
            R_RTY:   wb_rty_i = 1'b1;
            R_ERR:   wb_err_i = 1'b1;
            R_HOLD:  begin quiet = 1'b1; hold_cnt = 1; end
            default: wb_ack_i = 1'b1;
          endcase
        end
        idle_run = 0;
      end
    end
  endtask

  task automatic wait_q(input int level, input string tag);
    int n = 0;
    while (exp_q.size() > level && n < 3000) begin
      @(negedge wb_clk);
      n++;
    end
    if (exp_q.size() > level) chk(tag, 32'(exp_q.size()), 32'(level));
  endtask

  // Enable, drop en once the queue is down to drop_at entries, then drain and settle.
  task automatic run_phase(input int drop_at, input string tag);
    en_i = 1'b1;
    wait_q(drop_at, {tag, "_drop"});
    en_i = 1'b0;
    wait_q(0, {tag, "_drain"});
    repeat (20) @(negedge wb_clk);
  endtask

  initial begin
    fork slave_loop(); join_none
    #23;
    chk("rst_adr", wb_adr_o, SRC_BASE);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_idx", 32'(word_idx_o), 32'd0);
    chk("cti", 32'(wb_cti_o), 32'd0);
    chk("bte", 32'(wb_bte_o), 32'd0);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    repeat (3) @(negedge wb_clk);
    chk("idle_no_en_busy", 32'(busy_o), 32'd0);

    // Four words with wrap; en dropped during the wrapped word.
    push_rd(0, -1, 1'b0, R_ACK); push_wr(0, 0, 1, 1'b0, R_ACK); push_wr(0, 1, 1, 1'b0, R_ACK);
    push_rd(1, 6, 1'b0, R_ACK);  push_wr(1, 0, 1, 1'b0, R_ACK); push_wr(1, 1, 1, 1'b0, R_ACK);
    push_rd(2, 6, 1'b0, R_ACK);  push_wr(2, 0, 1, 1'b0, R_ACK); push_wr(2, 1, 1, 1'b0, R_ACK);
    push_rd(0, 6, 1'b0, R_ACK);  push_wr(0, 0, 1, 1'b0, R_ACK); push_wr(0, 1, 1, 1'b0, R_ACK);
    run_phase(2, "phA");
    chk("phA_busy", 32'(busy_o), 32'd0);
    chk("phA_idx", 32'(word_idx_o), 32'd1);
    chk("phA_err", 32'(err_o), 32'd0);

    // Resume at word 1: rty on a write, err on a read, err on a write.
    push_rd(1, -1, 1'b0, R_ACK); push_wr(1, 0, 1, 1'b0, R_RTY);
    push_wr(1, 0, 1, 1'b0, R_ACK); push_wr(1, 1, 1, 1'b0, R_ACK);
    push_rd(2, 6, 1'b0, R_ERR);
    push_rd(0, 6, 1'b1, R_ACK); push_wr(0, 0, 1, 1'b1, R_ERR);
    push_rd(1, 6, 1'b1, R_ACK); push_wr(1, 0, 1, 1'b1, R_ACK); push_wr(1, 1, 1, 1'b1, R_ACK);
    run_phase(2, "phB");
    chk("phB_busy", 32'(busy_o), 32'd0);
    chk("phB_idx", 32'(word_idx_o), 32'd2);
    chk("phB_err", 32'(err_o), 32'd1);

    // Reset asserted while a write is outstanding.
    push_rd(2, -1, 1'b1, R_ACK); push_wr(2, 0, 1, 1'b1, R_HOLD);
    en_i = 1'b1;
    wait_q(0, "phC_q");
    chk("phC_we_before", 32'(wb_we_o), 32'd1);
    #2 wb_rst_n = 1'b0;
    #1;
    chk("phC_cyc", 32'(wb_cyc_o), 32'd0);
    chk("phC_stb", 32'(wb_stb_o), 32'd0);
    chk("phC_we", 32'(wb_we_o), 32'd0);
    chk("phC_err", 32'(err_o), 32'd0);
    quiet = 1'b0;
    push_rd(0, -1, 1'b0, R_ACK); push_wr(0, 0, 1, 1'b0, R_ACK); push_wr(0, 1, 1, 1'b0, R_ACK);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    run_phase(2, "phC");
    chk("phC_busy", 32'(busy_o), 32'd0);
    chk("phC_idx", 32'(word_idx_o), 32'd1);

`ifdef PLAYER_TIMEOUT_EN
    // Slave never answers: the watchdog must abort after 1023 strobed cycles.
    begin
      int n = 0;
      push_rd(1, -1, 1'b0, R_HOLD);
      en_i = 1'b1;
      wait_q(0, "phD_q");
      while (wb_stb_o && n < 1100) begin
        @(negedge wb_clk);
        n++;
      end
      en_i  = 1'b0;
      quiet = 1'b0;
      chk("wd_stb_cycles", 32'(hold_cnt), 32'd1023);
      chk("wd_err", 32'(err_o), 32'd1);
      repeat (20) @(negedge wb_clk);
      chk("wd_busy", 32'(busy_o), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_pattern_player.md
Name: wb_pattern_player

Overview:
- Wishbone B3 classic master that replays a word table from ROM into a byte-addressed output peripheral (LEDs, 7-seg).
- Generalises the single-table ROM->LED mapper: parametrised table length, byte count per word and inter-word gap.
- Adds retry/error handling, an enable input and status outputs.
- Sits on the system bus beside the CPU; it is the only master on its own arbiter port.

Parameters:
- SRC_BASE, 32'h08000000, byte address of table word 0
- SRC_WORDS, 10, table length in 32-bit words (>=1)
- DST_BASE, 32'h91000000, byte address of first output byte
- DST_BYTES, 2, bytes written per table word (1..4), LSB first
- GAP_CYCLES, 0, idle cycles after each word's writes (0..2^16-1)

Ports:
- wb_clk  in  1  clock
- wb_rst_n  in  1  asynchronous active-low reset
- en_i  in  1  playback enable
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  bus error
- wb_rty_i  in  1  retry
- wb_adr_o  out  32  address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte select
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_cti_o  out  3  constant 3'b000
- wb_bte_o  out  2  constant 2'b00
- busy_o  out  1  high in any state except IDLE
- err_o  out  1  sticky; set on wb_err_i, cleared only by reset
- word_idx_o  out  $clog2(SRC_WORDS)  index of the current or next table word

Behaviour:
- Reset (async, wb_rst_n=0): state IDLE; all outputs 0 except wb_adr_o=SRC_BASE; word index 0, byte index 0.
- States: IDLE, RD, WR, BACKOFF, GAP. wb_cyc_o=wb_stb_o=1 only in RD and WR; wb_we_o=1 only in WR.
- IDLE: when en_i=1, go to RD next cycle with adr=SRC_BASE+4*idx and sel=4'hF.
- RD, on ack: latch wb_dat_i; byte=0; go to WR.
  - WR address = DST_BASE+byte.
  - Lane L = address[1:0].
  - wb_dat_o = data byte[byte] replicated into all four lanes.
  - wb_sel_o = 1<<L.
- WR, on ack: if byte==DST_BYTES-1, go to GAP (or straight to the next word if GAP_CYCLES==0). Otherwise byte+1 and re-issue WR next cycle.
- Next word: idx = (idx==SRC_WORDS-1) ? 0 : idx+1. If en_i=1 go to RD, else IDLE.
- Latency: one idle cycle (cyc=0) between consecutive accesses, so every access needs >=2 cycles.
- Priority on the same cycle: err > rty > ack.
- rty in RD/WR: drop cyc/stb, go to BACKOFF for 1 cycle, then re-issue the identical access (address, data, sel unchanged). No retry limit.
- err in RD: set err_o; skip the word's writes; go to GAP/next word.
- err in WR: set err_o; skip the remaining bytes of the word; go to GAP/next word.
- GAP: a 16-bit counter counts GAP_CYCLES cycles, then advances the word.
- en_i deassert:
  - Sampled only at word boundaries.
  - An access already started completes its whole word (all byte writes).
  - idx is preserved, so re-enabling resumes at the next word.
- Reset mid-access: cyc/stb drop asynchronously; the slave must tolerate an abandoned cycle.
- wb_adr_o and wb_dat_o are registered and hold stable while stb=1.

Optional Feature:
- PLAYER_TIMEOUT_EN defined:
  - A 10-bit watchdog counts cycles with stb=1 and no ack/err/rty.
  - At 1023 it aborts the access exactly as wb_err_i would (sets err_o, skips to next word).
  - The watchdog clears on every new access.
- Not defined: no watchdog, and a missing ack hangs the player forever.

Decomposition:
- Package wb_player_pkg:
  - state enum (IDLE, RD, WR, BACKOFF, GAP)
  - CTI_CLASSIC=3'b000, BTE_LINEAR=2'b00
  - the helper function for lane select from address[1:0]
- One sub-module: wb_player_gap_timer, a loadable down-counter with a done pulse. It is reused for the watchdog when PLAYER_TIMEOUT_EN is defined.

Test Plan:
- Defaults, en_i=1, ROM word0=32'hA1B2C3D4, zero-wait ack slave -> read at 0x08000000, then writes 0x91000000 sel=4'b0001 dat=32'hD4D4D4D4 and 0x91000001 sel=4'b0010 dat=32'hC3C3C3C3, then read at 0x08000004.
- SRC_WORDS=3, run 4 words -> read addresses 0x..00, 0x..04, 0x..08, then 0x..00 (wrap); word_idx_o sequence 0,1,2,0.
- rty on the first WR attempt -> 1 BACKOFF cycle with cyc=0, then the identical address/sel/dat re-issued; err_o stays 0.
- err on RD of word1 -> err_o=1, no writes for word1, next read at SRC_BASE+8.
- GAP_CYCLES=5 -> exactly 5 cycles with cyc=0 plus the single inter-access idle cycle between the last write and the next read. en_i dropped mid-word -> the word's writes still complete, then IDLE with busy_o=0; re-enable resumes at idx+1.
- Async reset asserted mid-WR -> cyc/stb/we go to 0 immediately; after release, playback restarts at SRC_BASE. With PLAYER_TIMEOUT_EN and a slave that never acks -> abort after 1023 cycles and err_o=1.
